// File: rtl/mill_pkg.sv
// Shared types and constants for the Modified Miller receive deframer.
package mill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    END
  } state_e;

  localparam int unsigned CHAR_BITS        = 9;
  localparam int unsigned SHORT_FRAME_BITS = 7;
  localparam int unsigned DATA_BITS        = 8;

endpackage

// File: rtl/mill_frame_deframer_etu_timeout.sv
// Idle-silence counter: cleared while held or on every bit strobe, flags the
// last idle cycle so the frame can be closed on the following edge.
module etu_timeout #(
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic strobe,
  output logic expire
);

  localparam int unsigned TW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(IDLE_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          clear;

  assign clear  = hold | strobe;
  // A strobe on the expiry cycle takes priority over the timeout.
  assign expire = !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mill_frame_deframer.sv
// Strips SOF, assembles parity-checked characters and short frames from the
// decoded Miller bit stream; frame end is detected by strobe silence.
module mill_frame_deframer
  import mill_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_enable,
  input  logic             in_bit,
  input  logic             in_bit_valid,
  output logic [7:0]       out_byte,
  output logic             out_byte_valid,
  output logic             out_parity_err,
  output logic             out_frame_start,
  output logic             out_frame_end,
  output logic             out_short,
  output logic             out_abort,
  output logic [3:0]       out_residual,
  output logic [CNT_W-1:0] out_byte_count
);

  state_e                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [7:0]             byte_d;
  logic                   byte_valid_d, parity_err_d, start_d, end_d;
  logic                   short_d, abort_d;
  logic [3:0]             residual_d;
  logic [CNT_W-1:0]       count_d;
  logic                   timer_hold, expire;

  assign timer_hold = (state_q != DATA);

  etu_timeout #(
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (timer_hold),
    .strobe(in_bit_valid),
    .expire(expire)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    byte_d       = out_byte;
    parity_err_d = out_parity_err;
    short_d      = out_short;
    abort_d      = out_abort;
    residual_d   = out_residual;
    count_d      = out_byte_count;
    byte_valid_d = 1'b0;
    start_d      = 1'b0;
    end_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_enable && in_bit_valid) begin
          state_d   = DATA;
          start_d   = 1'b1;
          count_d   = '0;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      DATA: begin
        if (!in_enable) begin
          state_d    = IDLE;
          end_d      = 1'b1;
          abort_d    = 1'b1;
          short_d    = 1'b0;
          residual_d = bit_cnt_q;
        end else if (in_bit_valid) begin
          if (bit_cnt_q == 4'(CHAR_BITS - 1)) begin
            byte_d       = shreg_q;
            parity_err_d = (in_bit != ~^shreg_q);
            byte_valid_d = 1'b1;
            bit_cnt_d    = '0;
            if (out_byte_count != '1) begin
              count_d = out_byte_count + 1'b1;
            end
          end else begin
            shreg_d[bit_cnt_q[2:0]] = in_bit;
            bit_cnt_d               = bit_cnt_q + 4'd1;
          end
        end else if (expire) begin
          // The END cycle is the one in which the close pulse is visible.
          state_d = END;
          end_d   = 1'b1;
          abort_d = 1'b0;
          if ((out_byte_count == '0) && (bit_cnt_q == 4'(SHORT_FRAME_BITS))) begin
            short_d      = 1'b1;
            residual_d   = '0;
            byte_d       = {1'b0, shreg_q[6:0]};
            parity_err_d = 1'b0;
            byte_valid_d = 1'b1;
          end else begin
            short_d    = 1'b0;
            residual_d = bit_cnt_q;
          end
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      shreg_q         <= '0;
      out_byte        <= '0;
      out_byte_valid  <= 1'b0;
      out_parity_err  <= 1'b0;
      out_frame_start <= 1'b0;
      out_frame_end   <= 1'b0;
      out_short       <= 1'b0;
      out_abort       <= 1'b0;
      out_residual    <= '0;
      out_byte_count  <= '0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shreg_q         <= shreg_d;
      out_byte        <= byte_d;
      out_byte_valid  <= byte_valid_d;
      out_parity_err  <= parity_err_d;
      out_frame_start <= start_d;
      out_frame_end   <= end_d;
      out_short       <= short_d;
      out_abort       <= abort_d;
      out_residual    <= residual_d;
      out_byte_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_mill_frame_deframer.sv
// Directed bench for mill_frame_deframer with hand-computed expectations.
module tb_mill_frame_deframer;

  logic       clk;
  logic       rst_n;
  logic       in_enable;
  logic       in_bit;
  logic       in_bit_valid;
  logic [7:0] out_byte;
  logic       out_byte_valid;
  logic       out_parity_err;
  logic       out_frame_start;
  logic       out_frame_end;
  logic       out_short;
  logic       out_abort;
  logic [3:0] out_residual;
  logic [7:0] out_byte_count;

  int checks = 0;
  int errors = 0;
  logic end_seen;
  logic bv_seen;

  mill_frame_deframer #(
    .IDLE_CYCLES(16),
    .CNT_W      (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_enable      (in_enable),
    .in_bit         (in_bit),
    .in_bit_valid   (in_bit_valid),
    .out_byte       (out_byte),
    .out_byte_valid (out_byte_valid),
    .out_parity_err (out_parity_err),
    .out_frame_start(out_frame_start),
    .out_frame_end  (out_frame_end),
    .out_short      (out_short),
    .out_abort      (out_abort),
    .out_residual   (out_residual),
    .out_byte_count (out_byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_frame_end === 1'b1) end_seen = 1'b1;
    if (out_byte_valid === 1'b1) bv_seen = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b);
    in_bit       = b;
    in_bit_valid = 1'b1;
    tick();
    in_bit_valid = 1'b0;
    in_bit       = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  initial begin
    rst_n        = 1'b0;
    in_enable    = 1'b1;
    in_bit       = 1'b0;
    in_bit_valid = 1'b0;
    end_seen     = 1'b0;
    bv_seen      = 1'b0;
    #1;
    idle(2);
    chk("reset_byte", out_byte, 8'h00);
    chk("reset_pulses", {out_byte_valid, out_frame_start, out_frame_end}, 3'b000);
    chk("reset_flags", {out_parity_err, out_short, out_abort}, 3'b000);
    chk("reset_residual", out_residual, 4'd0);
    chk("reset_count", out_byte_count, 8'd0);
    rst_n = 1'b1;
    idle(2);

    // REQA short frame: SOF + 7 bits of 0x26.
    send_bit(1'b0);
    chk("reqa_start", out_frame_start, 1'b1);
    send_bits(8'h26, 7);
    chk("reqa_start_once", out_frame_start, 1'b0);
    end_seen = 1'b0;
    idle(15);
    chk("reqa_no_early_end", end_seen, 1'b0);
    tick();
    chk("reqa_end", out_frame_end, 1'b1);
    chk("reqa_short", out_short, 1'b1);
    chk("reqa_byte_valid", out_byte_valid, 1'b1);
    chk("reqa_byte", out_byte, 8'h26);
    chk("reqa_count", out_byte_count, 8'd0);
    chk("reqa_residual", out_residual, 4'd0);
    tick();
    chk("reqa_end_single", {out_frame_end, out_byte_valid}, 2'b00);
    idle(3);

    // SEL frame: 0x93 (parity 1), 0x20 (parity 0).
    send_bit(1'b1);
    chk("sel_start", out_frame_start, 1'b1);
    send_bits(8'h93, 8);
    send_bit(1'b1);
    chk("sel_b0_valid", out_byte_valid, 1'b1);
    chk("sel_b0_byte", out_byte, 8'h93);
    chk("sel_b0_perr", out_parity_err, 1'b0);
    chk("sel_b0_count", out_byte_count, 8'd1);
    send_bits(8'h20, 8);
    send_bit(1'b0);
    chk("sel_b1_valid", out_byte_valid, 1'b1);
    chk("sel_b1_byte", out_byte, 8'h20);
    chk("sel_b1_perr", out_parity_err, 1'b0);
    bv_seen = 1'b0;
    idle(16);
    chk("sel_end", out_frame_end, 1'b1);
    chk("sel_end_flags", {out_short, out_abort}, 2'b00);
    chk("sel_count", out_byte_count, 8'd2);
    chk("sel_residual", out_residual, 4'd0);
    chk("sel_no_extra_byte", bv_seen, 1'b0);
    idle(3);

    // Parity error on 0x93, then 4 leftover bits; check end latency.
    send_bit(1'b0);
    send_bits(8'h93, 8);
    send_bit(1'b0);
    chk("perr_byte", out_byte, 8'h93);
    chk("perr_flag", out_parity_err, 1'b1);
    send_bits(8'h0D, 4);
    end_seen = 1'b0;
    idle(15);
    chk("resid_no_early_end", end_seen, 1'b0);
    tick();
    chk("resid_end", out_frame_end, 1'b1);
    chk("resid_residual", out_residual, 4'd4);
    chk("resid_short", out_short, 1'b0);
    chk("resid_count", out_byte_count, 8'd1);
    idle(3);

    // Strobe on the would-be expiry cycle keeps the frame open.
    send_bit(1'b0);
    send_bits(8'hA5, 4);
    end_seen = 1'b0;
    idle(15);
    send_bit(1'b0);
    chk("boundary_no_end", end_seen, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("boundary_byte", out_byte, 8'hA5);
    chk("boundary_valid", out_byte_valid, 1'b1);
    chk("boundary_perr", out_parity_err, 1'b0);
    chk("boundary_still_open", end_seen, 1'b0);
    idle(16);
    chk("boundary_end", out_frame_end, 1'b1);
    chk("boundary_count", out_byte_count, 8'd1);
    idle(3);

    // Abort after 3 data bits.
    send_bit(1'b0);
    send_bits(8'h05, 3);
    bv_seen   = 1'b0;
    in_enable = 1'b0;
    tick();
    chk("abort_end", out_frame_end, 1'b1);
    chk("abort_flag", out_abort, 1'b1);
    chk("abort_residual", out_residual, 4'd3);
    chk("abort_no_byte", bv_seen, 1'b0);
    tick();
    chk("abort_end_single", out_frame_end, 1'b0);

    // Disabled in IDLE: strobes ignored.
    send_bit(1'b1);
    chk("disabled_no_start", out_frame_start, 1'b0);
    end_seen = 1'b0;
    bv_seen  = 1'b0;
    send_bits(8'hFF, 8);
    idle(20);
    chk("disabled_quiet", {end_seen, bv_seen}, 2'b00);
    in_enable = 1'b1;
    idle(2);

    // Reset mid-byte.
    send_bit(1'b0);
    send_bits(8'h5A, 8);
    send_bit(1'b1);
    chk("rst_pre_byte", out_byte, 8'h5A);
    chk("rst_pre_count", out_byte_count, 8'd1);
    send_bits(8'h07, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_byte", out_byte, 8'h00);
    chk("rst_async_count", out_byte_count, 8'd0);
    end_seen = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    chk("rst_no_end", end_seen, 1'b0);
    send_bit(1'b0);
    chk("rst_restart", out_frame_start, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mill_frame_deframer.md
# mill_frame_deframer

Receive-path stage directly downstream of the Modified Miller decoder in the ISO 14443-A reader-to-card path. It consumes the decoded NRZ-L bit stream plus a per-bit strobe, strips the SOF bit, assembles 9-bit characters (8 data bits LSB-first plus odd parity), checks parity, and recognises 7-bit short frames (REQA/WUPA). End of frame is detected by bit-strobe silence. Bytes and frame markers are handed to the protocol layer as single-cycle pulses.

## Interface
- IDLE_CYCLES, 16: clocks without `in_bit_valid` that close a frame (2 ETU at 8 clk/ETU).
- CNT_W, 8: width of the byte counter (saturating).
- clk  in  1  fc/16 clock (847.5 kHz), same clock as the decoder.
- rst_n  in  1  asynchronous, active-low reset.
- in_enable  in  1  stage enable from the receive controller. Low means synchronous abort and hold in IDLE.
- in_bit  in  1  decoded NRZ-L bit from the Miller decoder.
- in_bit_valid  in  1  one-cycle strobe: `in_bit` is a new bit.
- out_byte  out  8  assembled data byte (short frame: bit 7 = 0).
- out_byte_valid  out  1  one-cycle pulse: `out_byte`/`out_parity_err` valid.
- out_parity_err  out  1  parity mismatch on this byte. Qualified by `out_byte_valid`.
- out_frame_start  out  1  one-cycle pulse when SOF is consumed.
- out_frame_end  out  1  one-cycle pulse at frame close.
- out_short  out  1  frame was a 7-bit short frame. Qualified by `out_frame_end`.
- out_abort  out  1  frame closed by `in_enable` drop. Qualified by `out_frame_end`.
- out_residual  out  4  leftover bits of an incomplete character (0–8). Qualified by `out_frame_end`.
- out_byte_count  out  CNT_W  bytes emitted in the current/last frame. Held after end, cleared at next start.

## Operation
- States:
  - IDLE: wait for the first `in_bit_valid`. That bit is SOF; its value is ignored. Pulse `out_frame_start`, clear `out_byte_count`, bit_cnt and timer, go to DATA.
  - DATA: on each `in_bit_valid`:
    - bit_cnt 0–7: shift `in_bit` into shreg at position bit_cnt (LSB-first). bit_cnt++.
    - bit_cnt 8: the bit is parity. `out_parity_err` = `in_bit` != ~^shreg. Emit the byte, bit_cnt = 0, `out_byte_count`++ (saturate at all-ones).
    - The timer resets on every strobe.
  - DATA without a strobe: the timer increments. At timer == IDLE_CYCLES-1 go to END.
  - END: a single cycle.
    - If `out_byte_count` == 0 and bit_cnt == 7: `out_short` = 1, emit `out_byte` = {1'b0, shreg[6:0]} with `out_byte_valid` in the same cycle, residual 0.
    - Otherwise `out_residual` = bit_cnt.
    - Pulse `out_frame_end`, then go to IDLE.
- `in_enable` low in DATA: next cycle pulse `out_frame_end` with `out_abort` = 1 and `out_residual` = bit_cnt. No byte is emitted. Go to IDLE.
- `in_enable` low in IDLE or END: strobes are ignored and no pulses are generated.
- `in_bit_valid` in the same cycle the timer would expire: the bit wins, is processed normally, and the timer resets.
- `in_bit_valid` during END is dropped (frame spacing guarantees ≥2 ETU).

## Timing
- All outputs are registered.
- Reset values: all pulses 0, `out_byte` 0, `out_byte_count` 0, `out_residual` 0, flags 0, state IDLE.
- `out_frame_start`: 1 clk after the SOF strobe.
- `out_byte_valid`: 1 clk after the parity-bit strobe.
- `out_frame_end`: IDLE_CYCLES+1 clk after the last strobe (timer expiry plus the END cycle). Abort: 1 clk after `in_enable` is sampled low.
- At most one of `out_frame_start` / `out_byte_valid` per cycle, except in a short-frame END, where `out_byte_valid` and `out_frame_end` coincide.
- Reset mid-frame: immediate return to reset values. No `out_frame_end` is generated.

## Structure
- Package `mill_pkg`:
  - state enum {IDLE, DATA, END}
  - constants CHAR_BITS = 9, SHORT_FRAME_BITS = 7, DATA_BITS = 8
- Sub-module `etu_timeout`: loadable idle counter with clear-on-strobe and a single-cycle expiry output, parameterised by IDLE_CYCLES. The FSM, shift register and parity logic stay in the top level.

## Test plan
- REQA: SOF + 7 bits of 0x26 (0,1,1,0,0,1,0), then silence → `out_frame_end`, `out_short` = 1, `out_byte` = 0x26, `out_byte_valid` in the same cycle, `out_byte_count` = 0.
- SEL frame: SOF + 0x93 (parity 1) + 0x20 (parity 0) → two byte pulses 0x93 and 0x20 with `out_parity_err` = 0, frame end with `out_byte_count` = 2 and `out_residual` = 0.
- 0x93 sent with parity 0 → `out_byte` = 0x93, `out_parity_err` = 1. The frame continues normally.
- Frame of 1 byte + 4 bits → `out_frame_end` with `out_residual` = 4, `out_short` = 0, exactly IDLE_CYCLES+1 clk after the last strobe.
- Strobe arrives on the cycle the timer reaches IDLE_CYCLES-1 → no frame end; the next byte assembles correctly.
- `in_enable` dropped after 3 data bits → `out_frame_end` with `out_abort` = 1, `out_residual` = 3, and no byte. Separately, rst_n asserted mid-byte → all outputs return to 0 at once, and no end pulse is generated.
